// File: rtl/gate_truth_checker_if.sv
// Bundle between the gate truth checker and the gate block it exercises:
// stimulus out, gate outputs back, plus run control and result reporting.
interface gate_truth_checker_if;
    logic       start;
    logic [7:0] gate_out;
    logic       a;
    logic       b;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_vec;
    logic [7:0] err_bits;
    logic [2:0] fail_count;

    modport master (
        output start, gate_out,
        input  a, b, busy, done, pass, err_vec, err_bits, fail_count
    );

    modport slave (
        input  start, gate_out,
        output a, b, busy, done, pass, err_vec, err_bits, fail_count
    );
endinterface

// File: rtl/gate_truth_checker.sv
// Walks {a,b} through 00..11, lets the gate block settle, samples its eight
// outputs once per vector and accumulates per-vector and per-gate mismatches.
module gate_truth_checker #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter logic [7:0]  CHECK_MASK    = 8'hFF
) (
    input logic                  clk,
    input logic                  rst_n,
    gate_truth_checker_if.slave  bus
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_CHECK  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    logic [1:0] state;
    logic [1:0] idx;
    logic [7:0] settle_cnt;
    logic       a_q;
    logic       b_q;
    logic       busy_q;
    logic       done_q;
    logic       pass_q;
    logic [3:0] err_vec_q;
    logic [7:0] err_bits_q;
    logic [2:0] fail_count_q;
    logic [7:0] expected;
    logic [7:0] mism;

    // Golden truth table for the vector currently applied ({a,b} == idx).
    always_comb begin
        expected[0] = idx[1] & idx[0];
        expected[1] = idx[1] | idx[0];
        expected[2] = ~(idx[1] & idx[0]);
        expected[3] = ~(idx[1] | idx[0]);
        expected[4] = idx[1] ^ idx[0];
        expected[5] = ~(idx[1] ^ idx[0]);
        expected[6] = ~idx[1];
        expected[7] = ~idx[0];
    end

    assign mism = (bus.gate_out ^ expected) & CHECK_MASK;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            idx          <= 2'd0;
            settle_cnt   <= 8'd0;
            a_q          <= 1'b0;
            b_q          <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_vec_q    <= 4'd0;
            err_bits_q   <= 8'd0;
            fail_count_q <= 3'd0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        err_vec_q    <= 4'd0;
                        err_bits_q   <= 8'd0;
                        fail_count_q <= 3'd0;
                        pass_q       <= 1'b0;
                        idx          <= 2'd0;
                        a_q          <= 1'b0;
                        b_q          <= 1'b0;
                        busy_q       <= 1'b1;
                        settle_cnt   <= 8'd0;
                        state        <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= 8'd0;
                        state      <= ST_CHECK;
                    end else begin
                        settle_cnt <= settle_cnt + 8'd1;
                    end
                end
                ST_CHECK: begin
                    if (mism != 8'd0) begin
                        err_vec_q[idx] <= 1'b1;
                        err_bits_q     <= err_bits_q | mism;
                        fail_count_q   <= fail_count_q + 3'd1;
                    end
                    if (idx != 2'd3) begin
                        idx        <= idx + 2'd1;
                        {a_q, b_q} <= idx + 2'd1;
                        state      <= ST_SETTLE;
                    end else begin
                        // The last vector's own result must be folded into pass here.
                        pass_q <= (err_vec_q == 4'd0) && (mism == 8'd0);
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= ST_DONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.a          = a_q;
    assign bus.b          = b_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.err_vec    = err_vec_q;
    assign bus.err_bits   = err_bits_q;
    assign bus.fail_count = fail_count_q;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Directed bench for gate_truth_checker: table of faulted gate-block runs,
// plus reset-mid-run, masked-gate and back-to-back short-settle sequences.
module tb_gate_truth_checker;

    typedef struct {
        string      name;
        logic [7:0] fmask;
        logic [7:0] fval;
        int         fault_from;
        int         fault_to;
        int         mid_start;
        logic       exp_pass;
        logic [3:0] exp_ev;
        logic [7:0] exp_eb;
        logic [2:0] exp_fc;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_applied = 0;
    int   n_miscompare = 0;

    logic [7:0] fault_mask = 8'h00;
    logic [7:0] fault_val  = 8'h00;
    logic       fault_on   = 1'b0;

    gate_truth_checker_if ifa();
    gate_truth_checker_if ifm();
    gate_truth_checker_if ifs();

    always #5 clk = ~clk;

    // Reference gate block: {o8..o1} = {~b,~a,xnor,xor,nor,nand,or,and}.
    function automatic logic [7:0] gm(input logic a, input logic b);
        return {~b, ~a, ~(a ^ b), a ^ b, ~(a | b), ~(a & b), a | b, a & b};
    endfunction

    assign ifa.gate_out = fault_on ? ((gm(ifa.a, ifa.b) & ~fault_mask) | (fault_val & fault_mask))
                                   : gm(ifa.a, ifa.b);
    assign ifm.gate_out = gm(ifm.a, ifm.b) & 8'h7F;
    assign ifs.gate_out = gm(ifs.a, ifs.b);

    gate_truth_checker dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    gate_truth_checker #(.CHECK_MASK(8'h0F)) dut_m (.clk(clk), .rst_n(rst_n), .bus(ifm.slave));
    gate_truth_checker #(.SETTLE_CYCLES(1)) dut_s (.clk(clk), .rst_n(rst_n), .bus(ifs.slave));

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miscompare++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        int   done_cyc;
        int   extra;
        logic busy1;
        logic busy_done;
        done_cyc  = -1;
        extra     = 0;
        busy1     = 1'b0;
        busy_done = 1'b1;
        @(negedge clk);
        fault_mask = v.fmask;
        fault_val  = v.fval;
        fault_on   = (v.fault_from == 0);
        ifa.start  = 1'b1;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            ifa.start = (v.mid_start != 0) && (cyc == v.mid_start);
            fault_on  = (cyc >= v.fault_from) && (cyc <= v.fault_to);
            if (cyc == 1) busy1 = ifa.busy;
            if (ifa.done) begin
                done_cyc  = cyc;
                busy_done = ifa.busy;
                break;
            end
        end
        ifa.start = 1'b0;
        fault_on  = 1'b0;
        checkOutput({v.name, ":done_cycle"}, 32'(done_cyc), 32'd21);
        checkOutput({v.name, ":busy_start"}, 32'(busy1), 32'd1);
        checkOutput({v.name, ":busy_done"}, 32'(busy_done), 32'd0);
        checkOutput({v.name, ":pass"}, 32'(ifa.pass), 32'(v.exp_pass));
        checkOutput({v.name, ":err_vec"}, 32'(ifa.err_vec), 32'(v.exp_ev));
        checkOutput({v.name, ":err_bits"}, 32'(ifa.err_bits), 32'(v.exp_eb));
        checkOutput({v.name, ":fail_count"}, 32'(ifa.fail_count), 32'(v.exp_fc));
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (ifa.done) extra++;
        end
        checkOutput({v.name, ":extra_done"}, 32'(extra), 32'd0);
        checkOutput({v.name, ":hold_pass"}, 32'(ifa.pass), 32'(v.exp_pass));
        checkOutput({v.name, ":hold_err_vec"}, 32'(ifa.err_vec), 32'(v.exp_ev));
    endtask

    initial begin
        vec_t tbl[9];
        vec_t clean;
        int   seen;
        int   done_at[4];
        int   n_done;

        tbl[0] = '{"clean",     8'h00, 8'h00, 0, 0,  0, 1'b1, 4'b0000, 8'h00, 3'd0};
        tbl[1] = '{"xor_lo",    8'h10, 8'h00, 0, 99, 0, 1'b0, 4'b0110, 8'h10, 3'd2};
        tbl[2] = '{"o8_lo",     8'h80, 8'h00, 0, 99, 0, 1'b0, 4'b0101, 8'h80, 3'd2};
        tbl[3] = '{"and_hi",    8'h01, 8'h01, 0, 99, 0, 1'b0, 4'b0111, 8'h01, 3'd3};
        tbl[4] = '{"nota_hi",   8'h40, 8'h40, 0, 99, 0, 1'b0, 4'b1100, 8'h40, 3'd2};
        tbl[5] = '{"all_lo",    8'hFF, 8'h00, 0, 99, 0, 1'b0, 4'b1111, 8'hFF, 3'd4};
        tbl[6] = '{"sample_hit",8'h01, 8'h01, 5, 5,  0, 1'b0, 4'b0001, 8'h01, 3'd1};
        tbl[7] = '{"glitch",    8'h01, 8'h01, 1, 4,  0, 1'b1, 4'b0000, 8'h00, 3'd0};
        tbl[8] = '{"mid_start", 8'h00, 8'h00, 0, 0, 10, 1'b1, 4'b0000, 8'h00, 3'd0};
        clean  = tbl[0];

        ifa.start = 1'b0;
        ifm.start = 1'b0;
        ifs.start = 1'b0;

        #1;
        checkOutput("reset_ab", 32'({ifa.a, ifa.b}), 32'd0);
        checkOutput("reset_busy_done_pass", 32'({ifa.busy, ifa.done, ifa.pass}), 32'd0);
        checkOutput("reset_results", 32'({ifa.err_vec, ifa.err_bits, ifa.fail_count}), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) applyStimulus(tbl[i]);

        // Reset in the middle of vector 1 ({a,b}=01) must abort the run at once.
        @(negedge clk);
        ifa.start = 1'b1;
        seen = 0;
        for (int cyc = 1; cyc <= 7; cyc++) begin
            @(negedge clk);
            ifa.start = 1'b0;
            if (cyc == 6) checkOutput("rst_pre_ab", 32'({ifa.a, ifa.b}), 32'd1);
        end
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_ab", 32'({ifa.a, ifa.b}), 32'd0);
        checkOutput("rst_mid_busy", 32'(ifa.busy), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ifa.done) seen++;
        end
        checkOutput("rst_no_done", 32'(seen), 32'd0);
        applyStimulus(clean);

        // o8 stuck low is invisible when only gates 0..3 are checked.
        @(negedge clk);
        ifm.start = 1'b1;
        seen = -1;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            ifm.start = 1'b0;
            if (ifm.done) begin
                seen = cyc;
                break;
            end
        end
        checkOutput("mask_done_cycle", 32'(seen), 32'd21);
        checkOutput("mask_pass", 32'(ifm.pass), 32'd1);
        checkOutput("mask_err_bits", 32'(ifm.err_bits), 32'd0);

        // Short settle with start held: back-to-back runs every 10 cycles.
        for (int i = 0; i < 4; i++) done_at[i] = -1;
        n_done = 0;
        @(negedge clk);
        ifs.start = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (cyc == 1 || cyc == 3 || cyc == 5 || cyc == 7)
                checkOutput("s1_ab_seq", 32'({ifs.a, ifs.b}), 32'((cyc - 1) / 2));
            if (ifs.done) begin
                if (n_done < 4) done_at[n_done] = cyc;
                n_done++;
                checkOutput("s1_pass", 32'(ifs.pass), 32'd1);
            end
        end
        ifs.start = 1'b0;
        checkOutput("s1_done_count", 32'(n_done), 32'd4);
        checkOutput("s1_done0", 32'(done_at[0]), 32'd9);
        checkOutput("s1_done1", 32'(done_at[1]), 32'd19);
        checkOutput("s1_done2", 32'(done_at[2]), 32'd29);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompare);
        $finish;
    end

endmodule
